// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: stall encodings, stage bit indices,
// mult/div sequencer state and a counter-width helper.
package pipe_pkg;

  localparam int STALL_W = 6;

  // Bit positions inside the stall vector
  localparam int ST_PC  = 0;
  localparam int ST_IF  = 1;
  localparam int ST_ID  = 2;
  localparam int ST_EX  = 3;
  localparam int ST_MEM = 4;
  localparam int ST_WB  = 5;

  // A stall from stage S holds S and every stage upstream of it
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Bits needed to hold values 0..n (never less than 1)
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_md_seq.sv
// Mult/div busy sequencer: holds EX for N cycles (start cycle included),
// then pulses done for one cycle. An abort (exception) drops straight to IDLE.
module md_seq
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  input  logic abort,
  output logic ex_req,
  output logic busy,
  output logic done
);

  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = cnt_w(MAXC);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   load;

  // Next state / outputs. cnt holds the remaining BUSY cycles; BUSY is left
  // when the decremented count reaches zero, so BUSY lasts N-1 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ex_req  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    load    = is_div ? DIV_LOAD : MULT_LOAD;
    case (state_q)
      MD_IDLE, MD_DONE: begin
        done    = (state_q == MD_DONE);
        state_d = MD_IDLE;
        if (start) begin
          ex_req  = 1'b1;
          cnt_d   = load;
          state_d = (load == '0) ? MD_DONE : MD_BUSY;
        end
      end
      MD_BUSY: begin
        ex_req = 1'b1;
        busy   = 1'b1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_d == '0) state_d = MD_DONE;
      end
      default: state_d = MD_IDLE;
    endcase
    if (abort) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
      done    = 1'b0;
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall arbitration, PC redirect arbitration
// (exception over branch), mult/div sequencer and memory-wait timeout.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int          MULT_CYCLES = 4,
  parameter int          DIV_CYCLES  = 32,
  parameter int          MEM_TIMEOUT = 255,
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0180
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stallreq_id,
  input  logic               md_start,
  input  logic               md_is_div,
  input  logic               mem_req,
  input  logic               mem_ready,
  input  logic               exc_valid,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic               branchEnable,
  output logic [31:0]        branchAddress,
  output logic               md_busy,
  output logic               md_done,
  output logic               mem_timeout
);

  localparam int WW = cnt_w(MEM_TIMEOUT);
  localparam logic [WW-1:0] WMAX = WW'(MEM_TIMEOUT);

  logic          ex_req;
  logic          mem_rq;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          mem_timeout_q, mem_timeout_d;

  md_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_seq (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .is_div (md_is_div),
    .abort  (exc_valid),
    .ex_req (ex_req),
    .busy   (md_busy),
    .done   (md_done)
  );

  // Memory-wait counter: counts consecutive waiting cycles, saturates, and
  // latches the timeout flag on the edge where it reaches MEM_TIMEOUT.
  always_comb begin
    mem_rq        = mem_req & ~mem_ready;
    wcnt_d        = wcnt_q;
    mem_timeout_d = mem_timeout_q;
    if (exc_valid || !mem_rq)  wcnt_d = '0;
    else if (wcnt_q != WMAX)   wcnt_d = wcnt_q + WW'(1);
    if (mem_rq && !exc_valid && (wcnt_d == WMAX)) mem_timeout_d = 1'b1;
  end

  // Wait counter and sticky timeout registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q        <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      wcnt_q        <= wcnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

  // Stall and redirect arbitration; an exception flushes and wins everything.
  // Combinational so pc sees the stall at the same edge it acts on.
  always_comb begin
    stall         = STALL_NONE;
    flush         = 1'b0;
    branchEnable  = 1'b0;
    branchAddress = 32'h0;
    if (exc_valid) begin
      flush         = 1'b1;
      branchEnable  = 1'b1;
      branchAddress = EXC_VECTOR;
    end else begin
      if (mem_rq)           stall = STALL_MEM;
      else if (ex_req)      stall = STALL_EX;
      else if (stallreq_id) stall = STALL_ID;
      if (branch_taken) begin
        branchEnable  = 1'b1;
        branchAddress = branch_target;
      end
    end
  end

endmodule
